// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: pipeline-side signals of the hazard controller.
interface hazard_unit_mc_if #(parameter int ADDRESSWIDTH = 4);
    logic writeEnableDM, writeEnableDWB;
    logic [ADDRESSWIDTH-1:0] writeAddressM, writeAddressW, writeAddressE;
    logic [ADDRESSWIDTH-1:0] reg1ReadAddressE, reg2ReadAddressE;
    logic [ADDRESSWIDTH-1:0] reg1ReadAddressD, reg2ReadAddressD;
    logic reg1UsedD, reg2UsedD;
    logic [ADDRESSWIDTH-1:0] writeAddressD;
    logic regWriteD, resultSelectorWBE, mcStartE, mcStartD, takeBranchE;
    logic [1:0] data1ForwardSelectorE, data2ForwardSelectorE;
    logic stallF, stallD, flushE, flushD, mcBusy, mcDone;
    logic [ADDRESSWIDTH-1:0] mcWriteAddress;

    modport master (
        output writeEnableDM, writeEnableDWB, writeAddressM, writeAddressW, writeAddressE,
               reg1ReadAddressE, reg2ReadAddressE, reg1ReadAddressD, reg2ReadAddressD,
               reg1UsedD, reg2UsedD, writeAddressD, regWriteD, resultSelectorWBE,
               mcStartE, mcStartD, takeBranchE,
        input  data1ForwardSelectorE, data2ForwardSelectorE, stallF, stallD, flushE, flushD,
               mcBusy, mcDone, mcWriteAddress
    );

    modport slave (
        input  writeEnableDM, writeEnableDWB, writeAddressM, writeAddressW, writeAddressE,
               reg1ReadAddressE, reg2ReadAddressE, reg1ReadAddressD, reg2ReadAddressD,
               reg1UsedD, reg2UsedD, writeAddressD, regWriteD, resultSelectorWBE,
               mcStartE, mcStartD, takeBranchE,
        output data1ForwardSelectorE, data2ForwardSelectorE, stallF, stallD, flushE, flushD,
               mcBusy, mcDone, mcWriteAddress
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use stall FSM, multicycle-unit scoreboard and branch flush.
module hazard_unit_mc #(
    parameter int ADDRESSWIDTH = 4,
    parameter int MEMLATENCY   = 1,
    parameter int MCLATENCY    = 4,
    parameter int CNTWIDTH     = 4
) (
    input logic clk,
    input logic reset,
    hazard_unit_mc_if.slave bus
);
    typedef enum logic {RUN, LDSTALL} ld_state_t;
    typedef enum logic {IDLE, BUSY} mc_state_t;

    ld_state_t ld_state;
    mc_state_t mc_state;
    logic [CNTWIDTH-1:0] ld_count, mc_count;
    logic [ADDRESSWIDTH-1:0] mc_addr;
    logic d_dep_e, d_dep_mc, busy, ld_hit, ld_stall, mc_stall, stall;

    always_comb begin
        bus.data1ForwardSelectorE =
            (bus.writeEnableDM && bus.reg1ReadAddressE == bus.writeAddressM) ? 2'b10 :
            (bus.writeEnableDWB && bus.reg1ReadAddressE == bus.writeAddressW) ? 2'b01 : 2'b00;
        bus.data2ForwardSelectorE =
            (bus.writeEnableDM && bus.reg2ReadAddressE == bus.writeAddressM) ? 2'b10 :
            (bus.writeEnableDWB && bus.reg2ReadAddressE == bus.writeAddressW) ? 2'b01 : 2'b00;
    end

    assign d_dep_e  = (bus.reg1UsedD && bus.reg1ReadAddressD == bus.writeAddressE) ||
                      (bus.reg2UsedD && bus.reg2ReadAddressD == bus.writeAddressE);
    assign d_dep_mc = (bus.reg1UsedD && bus.reg1ReadAddressD == mc_addr) ||
                      (bus.reg2UsedD && bus.reg2ReadAddressD == mc_addr);
    assign busy     = mc_state == BUSY;
    assign ld_hit   = bus.resultSelectorWBE && d_dep_e;
    assign ld_stall = ld_state == LDSTALL || ld_hit;
    assign mc_stall = (bus.mcStartE && d_dep_e) ||
                      (busy && d_dep_mc) ||
                      (busy && bus.regWriteD && bus.writeAddressD == mc_addr) ||
                      (busy && bus.mcStartD) ||
                      (bus.mcStartE && bus.mcStartD);
    // A taken branch squashes D, so nothing there can still need holding.
    assign stall    = (ld_stall || mc_stall) && !bus.takeBranchE;

    assign bus.stallF         = stall;
    assign bus.stallD         = stall;
    assign bus.flushE         = stall || bus.takeBranchE;
    assign bus.flushD         = bus.takeBranchE;
    assign bus.mcBusy         = busy;
    assign bus.mcDone         = busy && mc_count == '0;
    assign bus.mcWriteAddress = mc_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_state <= RUN;
            ld_count <= '0;
            mc_state <= IDLE;
            mc_count <= '0;
            mc_addr  <= '0;
        end else begin
            if (bus.takeBranchE) begin
                ld_state <= RUN;
                ld_count <= '0;
            end else if (ld_state == RUN) begin
                if (ld_hit && MEMLATENCY > 1) begin
                    ld_state <= LDSTALL;
                    ld_count <= CNTWIDTH'(MEMLATENCY - 2);
                end
            end else if (ld_count == '0) begin
                ld_state <= RUN;
            end else begin
                ld_count <= ld_count - CNTWIDTH'(1);
            end
            // A start seen while busy is a stalled duplicate and is ignored.
            if (mc_state == IDLE) begin
                if (bus.mcStartE) begin
                    mc_state <= BUSY;
                    mc_count <= CNTWIDTH'(MCLATENCY - 1);
                    mc_addr  <= bus.writeAddressE;
                end
            end else if (mc_count == '0) begin
                mc_state <= IDLE;
            end else begin
                mc_count <= mc_count - CNTWIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed scoreboard bench, MEMLATENCY=3, MCLATENCY=4.
module tb_hazard_unit_mc;
    typedef struct packed {
        logic [1:0] f1, f2;
        logic sf, sd, fe, fd, bz, dn;
        logic [3:0] wa;
    } exp_t;

    logic clk, reset;
    int n_cmp = 0, n_err = 0;
    exp_t exp_q[$];
    string tag_q[$];
    exp_t obs;

    hazard_unit_mc_if #(.ADDRESSWIDTH(4)) bus ();

    hazard_unit_mc #(.ADDRESSWIDTH(4), .MEMLATENCY(3), .MCLATENCY(4), .CNTWIDTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.data1ForwardSelectorE, bus.data2ForwardSelectorE, bus.stallF, bus.stallD,
                  bus.flushE, bus.flushD, bus.mcBusy, bus.mcDone, bus.mcWriteAddress};

    function automatic exp_t mk(logic [1:0] f1, logic [1:0] f2, logic sf, logic sd, logic fe,
                                logic fd, logic bz, logic dn, logic [3:0] wa);
        exp_t e;
        e.f1 = f1; e.f2 = f2; e.sf = sf; e.sd = sd; e.fe = fe; e.fd = fd;
        e.bz = bz; e.dn = dn; e.wa = wa;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.writeEnableDM = 0; bus.writeEnableDWB = 0;
        bus.writeAddressM = 0; bus.writeAddressW = 0; bus.writeAddressE = 0;
        bus.reg1ReadAddressE = 0; bus.reg2ReadAddressE = 0;
        bus.reg1ReadAddressD = 0; bus.reg2ReadAddressD = 0;
        bus.reg1UsedD = 0; bus.reg2UsedD = 0;
        bus.writeAddressD = 0; bus.regWriteD = 0; bus.resultSelectorWBE = 0;
        bus.mcStartE = 0; bus.mcStartD = 0; bus.takeBranchE = 0;
    endtask

    task automatic check(input string tag, input exp_t e);
        exp_t x;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === x) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", t, obs, x);
        end
    endtask

    initial begin
        reset = 0;
        clear();
        tick(); tick();
        check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1;
        tick();

        bus.writeEnableDM = 1; bus.writeAddressM = 3; bus.writeEnableDWB = 1; bus.writeAddressW = 3;
        bus.reg1ReadAddressE = 3; bus.reg2ReadAddressE = 5;
        check("fwd_m", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        bus.writeEnableDM = 0;
        check("fwd_w", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        bus.writeEnableDM = 1; bus.writeAddressW = 5;
        check("fwd_mix", mk(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        clear();
        tick();

        bus.resultSelectorWBE = 1; bus.writeAddressE = 4; bus.reg1ReadAddressD = 4; bus.reg1UsedD = 0;
        check("ld_unused", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        bus.reg1UsedD = 1;
        check("ld_c0", mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        tick();
        bus.resultSelectorWBE = 0; bus.writeAddressE = 0;
        check("ld_c1", mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        tick();
        check("ld_c2", mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        tick();
        check("ld_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        clear();
        tick();

        bus.mcStartE = 1; bus.writeAddressE = 7; bus.reg1ReadAddressD = 7; bus.reg1UsedD = 1;
        check("mc_start", mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
        tick();
        bus.mcStartE = 0; bus.writeAddressE = 0;
        check("mc_t1", mk(0, 0, 1, 1, 1, 0, 1, 0, 7));
        tick();
        check("mc_t2", mk(0, 0, 1, 1, 1, 0, 1, 0, 7));
        tick();
        check("mc_t3", mk(0, 0, 1, 1, 1, 0, 1, 0, 7));
        tick();
        check("mc_t4_done", mk(0, 0, 1, 1, 1, 0, 1, 1, 7));
        tick();
        check("mc_t5_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 7));
        clear();
        tick();

        bus.mcStartE = 1; bus.writeAddressE = 9;
        check("st_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 7));
        tick();
        bus.mcStartE = 0; bus.writeAddressE = 0; bus.mcStartD = 1;
        check("structural", mk(0, 0, 1, 1, 1, 0, 1, 0, 9));
        tick();
        bus.mcStartD = 0; bus.regWriteD = 1; bus.writeAddressD = 9;
        check("waw", mk(0, 0, 1, 1, 1, 0, 1, 0, 9));
        tick();
        bus.writeAddressD = 2; bus.reg1ReadAddressD = 3; bus.reg1UsedD = 1;
        check("unrelated", mk(0, 0, 0, 0, 0, 0, 1, 0, 9));
        tick();
        check("st_done", mk(0, 0, 0, 0, 0, 0, 1, 1, 9));
        clear();
        tick();
        check("st_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 9));
        tick();

        bus.mcStartE = 1; bus.writeAddressE = 10;
        check("br_mc_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 9));
        tick();
        bus.mcStartE = 0; bus.resultSelectorWBE = 1; bus.writeAddressE = 4;
        bus.reg2ReadAddressD = 4; bus.reg2UsedD = 1;
        check("br_ld_c0", mk(0, 0, 1, 1, 1, 0, 1, 0, 10));
        tick();
        bus.resultSelectorWBE = 0; bus.writeAddressE = 0; bus.takeBranchE = 1;
        check("br_priority", mk(0, 0, 0, 0, 1, 1, 1, 0, 10));
        tick();
        bus.takeBranchE = 0;
        check("br_run", mk(0, 0, 0, 0, 0, 0, 1, 0, 10));
        tick();
        check("br_mc_done", mk(0, 0, 0, 0, 0, 0, 1, 1, 10));
        clear();
        tick();

        bus.mcStartE = 1; bus.writeAddressE = 6;
        check("rst_start", mk(0, 0, 0, 0, 0, 0, 0, 0, 10));
        tick();
        bus.mcStartE = 0; bus.writeAddressE = 0;
        check("rst_t1", mk(0, 0, 0, 0, 0, 0, 1, 0, 6));
        tick();
        reset = 0;
        check("rst_t2", mk(0, 0, 0, 0, 0, 0, 1, 0, 6));
        tick();
        reset = 1;
        check("rst_abort", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check("rst_no_done1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check("rst_no_done2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Pipeline hazard controller for the 5-stage core (F/D/E/M/W). It forwards operands into E from M and W and stalls on load-use hazards with a configurable memory latency. It tracks one outstanding multicycle operation (MUL/DIV unit) with a busy scoreboard and flushes D/E on taken branches. It replaces the single-cycle combinational hazard logic and sits between the decode/execute pipeline registers and the multicycle unit.

## Interface
Parameters:
- ADDRESSWIDTH, 4, register address width
- MEMLATENCY, 1, load-use stall length in cycles (≥1)
- MCLATENCY, 4, multicycle unit latency in cycles (≥2)
- CNTWIDTH, 4, width of both down-counters (must hold max(MEMLATENCY, MCLATENCY)−1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- writeEnableDM, writeEnableDWB  in  1  M/W stage register-write enables
- writeAddressM, writeAddressW, writeAddressE  in  ADDRESSWIDTH  destination registers per stage
- reg1ReadAddressE, reg2ReadAddressE  in  ADDRESSWIDTH  E-stage source registers
- reg1ReadAddressD, reg2ReadAddressD  in  ADDRESSWIDTH  D-stage source registers
- reg1UsedD, reg2UsedD  in  1  D instruction actually reads that source
- writeAddressD  in  ADDRESSWIDTH, regWriteD  in  1  D-stage destination and write flag
- resultSelectorWBE  in  1  E instruction is a load
- mcStartE  in  1  E instruction issues to the multicycle unit
- mcStartD  in  1  D instruction is a multicycle op
- takeBranchE  in  1  branch in E taken
- data1ForwardSelectorE, data2ForwardSelectorE  out  2  00 regfile, 01 W, 10 M
- stallF, stallD, flushE, flushD  out  1  pipeline controls
- mcBusy  out  1  multicycle unit occupied
- mcDone  out  1  one-cycle pulse: result ready, write mcWriteAddress this cycle
- mcWriteAddress  out  ADDRESSWIDTH  latched multicycle destination

## Operation
- Forwarding is combinational. For each E source, select 10 if writeEnableDM and address equals writeAddressM. Otherwise select 01 if writeEnableDWB and address equals writeAddressW. Otherwise select 00. M has priority over W.
- Multicycle ops enter M/W with write enables low. Their writeback happens only via mcDone.
- Load FSM states: RUN, LDSTALL.
  - Detection: resultSelectorWBE and (reg1UsedD and reg1ReadAddressD==writeAddressE, or reg2UsedD and reg2ReadAddressD==writeAddressE).
  - In RUN, detection asserts stallF, stallD and flushE in the same cycle.
  - If MEMLATENCY>1, detection moves the FSM to LDSTALL with ldCount=MEMLATENCY−2. LDSTALL holds stallF/stallD/flushE and decrements ldCount. At 0 it returns to RUN after that cycle.
  - MEMLATENCY=1 never enters LDSTALL.
- MC FSM states: IDLE, BUSY.
  - IDLE with mcStartE: latch mcWriteAddress=writeAddressE, set mcCount=MCLATENCY−1, go BUSY.
  - In BUSY, mcCount decrements each cycle. When mcCount==0: mcDone=1, then return to IDLE.
  - mcBusy=1 exactly while in BUSY.
- MC stall (stallF, stallD, flushE), asserted when any of:
  - mcStartE and a used D source equals writeAddressE;
  - BUSY and a used D source equals mcWriteAddress (RAW);
  - BUSY and regWriteD and writeAddressD==mcWriteAddress (WAW);
  - BUSY and mcStartD (structural);
  - mcStartE and mcStartD.
- Branch: takeBranchE forces flushD=1 and flushE=1. It overrides every stall: stallF=stallD=0, and the load FSM is forced to RUN. An MC op already in BUSY is not cancelled.
- Stall sources OR together. Outputs are combinational from state and inputs. Only the FSM and counter state is registered.

## Timing
- Reset (reset=0 at a rising edge):
  - Load FSM goes to RUN, MC FSM goes to IDLE, all counters and mcWriteAddress go to 0.
  - With takeBranchE=0, every output is 0.
  - Reset mid-BUSY or mid-LDSTALL aborts with no mcDone.
- Forwarding: zero latency.
- Load-use stall: exactly MEMLATENCY consecutive stall cycles starting in the detection cycle.
- MC op: start sampled at edge t. mcBusy is high from t+1 through t+MCLATENCY. mcDone is high in cycle t+MCLATENCY. A dependent D instruction is released in cycle t+MCLATENCY+1.
- Simultaneous mcDone and mcStartE: a new op cannot be in E (blocked by the structural stall), so that case is unreachable. mcStartE while BUSY is ignored.

## Test plan
- Forwarding: writeEnableDM=1, writeAddressM=3, writeEnableDWB=1, writeAddressW=3, reg1ReadAddressE=3, reg2ReadAddressE=5 -> data1ForwardSelectorE=10, data2ForwardSelectorE=00. Drop writeEnableDM -> data1ForwardSelectorE=01.
- Load-use, MEMLATENCY=3: load in E writing r4, D reads r4 with reg1UsedD=1 -> stallF/stallD/flushE high for 3 cycles, then low. The same case with reg1UsedD=0 -> no stall.
- MC RAW, MCLATENCY=4: mcStartE with writeAddressE=7 at edge t, D reads r7. Required: stall from the start cycle until mcDone in t+4, mcWriteAddress=7, release at t+5.
- Structural and WAW: while BUSY, mcStartD=1 -> stall. Separately, regWriteD=1 with writeAddressD=mcWriteAddress -> stall. An unrelated D instruction -> no stall.
- Branch priority: during LDSTALL, assert takeBranchE -> flushD=flushE=1, stallF=stallD=0, FSM back in RUN next cycle. mcBusy is unaffected.
- Reset mid-BUSY: reset=0 two cycles after start -> mcBusy=0 next cycle, mcDone never pulses, all outputs 0.
